// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: 2^ADDR_W-word instruction memory feeding the IF/ID register.
// The addressed word's opcode goes back to the PC as pc_scr so the PC can hold on halt.
module instr_fetch_stage #(
    parameter int              WIDTH   = 32,
    parameter int              ADDR_W  = 7,
    parameter logic [WIDTH-1:0] NOP    = 32'h0000_0013,
    parameter logic [6:0]      HALT_OP = 7'b1111111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WIDTH-1:0]  load_data,
    input  logic              stall,
    input  logic              flush,
    output logic [6:0]        pc_scr,
    output logic [WIDTH-1:0]  if_id_instr,
    output logic [WIDTH-1:0]  if_id_pc,
    output logic              if_id_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_word;

    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;
    logic [15:0]      count_q, count_d;

    // Memory is deliberately outside the reset domain so boot code survives rst.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign rd_word = mem_q[pc_in[ADDR_W-1:0]];
    assign pc_scr  = rd_word[6:0];

    always_comb begin
        instr_d  = instr_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        count_d  = count_q;
        if (flush) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (stall) begin
            instr_d = instr_q;
        end else if (load_en) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (halted_q) begin
            valid_d = 1'b0;
        end else begin
            instr_d = rd_word;
            pc_d    = pc_in;
            valid_d = 1'b1;
            count_d = count_q + 16'd1;
            if (rd_word[6:0] == HALT_OP) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            instr_q  <= NOP;
            pc_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            count_q  <= '0;
        end else begin
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            count_q  <= count_d;
        end
    end

    assign if_id_instr = instr_q;
    assign if_id_pc    = pc_q;
    assign if_id_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: doc/instr_fetch_stage.md
# instr_fetch_stage

Instruction fetch stage directly downstream of the program counter. It holds a 128-word instruction memory addressed by the PC's word address and latches the fetched word into the IF/ID pipeline register. It feeds the fetched opcode back to the PC's `pc_scr` input so the PC holds on a halt instruction. A load port lets the bench or boot logic fill the memory before execution.

## Interface
- `WIDTH`, 32, instruction and PC width.
- `ADDR_W`, 7, memory address width; the memory holds 2^ADDR_W words.
- `NOP`, 32'h0000_0013, bubble word inserted on flush, load and reset.
- `HALT_OP`, 7'b1111111, halt opcode; matches the PC halt encoding.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous active-low reset
- `pc_in`  in  WIDTH  current instruction word address from the PC
- `load_en`  in  1  memory write strobe
- `load_addr`  in  ADDR_W  memory write address
- `load_data`  in  WIDTH  memory write data
- `stall`  in  1  hold the IF/ID register (downstream hazard)
- `flush`  in  1  squash the IF/ID contents (taken branch/jump)
- `pc_scr`  out  7  combinational opcode of `mem[pc_in[ADDR_W-1:0]]`, driven to the PC
- `if_id_instr`  out  WIDTH  latched instruction
- `if_id_pc`  out  WIDTH  PC of the latched instruction
- `if_id_valid`  out  1  IF/ID holds a real instruction
- `halted`  out  1  sticky; a halt instruction has been issued
- `fetch_count`  out  16  number of instructions issued with valid=1

## Operation
- Memory: 2^ADDR_W x WIDTH words.
  - Written synchronously when `load_en`=1; the write is independent of `rst`.
  - Contents are not cleared by reset.
  - Read is asynchronous at `pc_in[ADDR_W-1:0]`; `pc_in[WIDTH-1:ADDR_W]` is ignored for addressing and passed through to `if_id_pc`.
- `pc_scr` = `mem[pc_in[6:0]][6:0]` at all times, including during reset and load. The PC holds whenever this equals HALT_OP.
- IF/ID update at each rising edge, with priority highest first:
  1. `rst`=0: instr=NOP, pc=0, valid=0, halted=0, fetch_count=0.
  2. `flush`=1: instr=NOP, valid=0, pc unchanged, halted unchanged.
  3. `stall`=1: all IF/ID outputs hold.
  4. `load_en`=1: instr=NOP, valid=0. No fetch happens in a load cycle.
  5. `halted`=1: instr and pc hold, valid=0.
  6. Otherwise (fetch): instr=`mem[pc_in]`, pc=`pc_in`, valid=1, fetch_count+1.
     - If the fetched opcode = HALT_OP, `halted` is set in the same edge, so the halt word issues exactly once with valid=1.
- `fetch_count` wraps from 16'hFFFF to 0.
- `halted` clears only on reset.

## Timing
- Fetch latency is 1 cycle. The word at `pc_in` during cycle n appears on `if_id_instr` after edge n, with valid=1.
- `pc_scr` has 0-cycle latency from `pc_in` or from a memory write (visible after the write edge).
- A write to the address currently on `pc_in` is visible to the fetch one cycle later. A write and a fetch never occur in the same cycle.
- Address wrap: the PC increments `pc_in[6:0]` modulo 128. A fetch at 127 followed by a fetch at 0 needs no special handling.
- Stall does not stop the PC (the PC has no stall input). Addresses presented during a stall are not fetched; the upstream hazard logic owns replay.
- Reset mid-stream: outputs are at their reset values after the first edge with `rst`=0. Memory contents survive the reset.

## Test plan
- Load: mem[0..3] = 0x00500093, 0x00A00113, 0x002081B3, 0x0000007F; release reset; PC runs.
  - Required: valid=1 with instructions in order at PC 0,1,2,3.
  - `pc_scr`=0x7F while `pc_in`=3; `halted`=1 after the halt issues.
  - valid=0 thereafter; fetch_count=4.
- Stall asserted for 2 cycles after instruction 0x00A00113 is latched.
  - Required: `if_id_instr` and `if_id_pc` hold for 2 cycles; fetch_count does not increment.
- Flush and stall asserted together in the same cycle.
  - Required: instr=0x00000013, valid=0 (flush wins); next unstalled cycle fetches `mem[pc_in]`.
- `load_en`=1 writing 0xDEADBEEF at the current `pc_in`.
  - Required: valid=0 that cycle; next cycle `if_id_instr`=0xDEADBEEF; `pc_scr` = 0x6F right after the write edge.
- `pc_in`=0x0000_0080 with mem[0]=0x00100093.
  - Required: fetches mem[0]; `if_id_pc`=0x80.
  - `pc_in`=127 followed by 0 fetches both back to back.
- `rst` pulsed low for 1 cycle while halted with fetch_count=4.
  - Required: halted=0, valid=0, fetch_count=0, instr=NOP; memory is intact and refetches 0x00500093.
